// File: rtl/exe_seq_ctrl.sv
// Multi-cycle control sequencer for the execute datapath and the shared
// instruction/data memory port, with memory-handshake timeout detection.
module exe_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TW          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ALUSrc,
  output logic       RegDest,
  output logic [2:0] aluc,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       busy,
  output logic       illegal_op,
  output logic       bus_err
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EX_R    = 4'd3;
  localparam logic [3:0] S_EX_ADDI = 4'd4;
  localparam logic [3:0] S_EX_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD  = 4'd6;
  localparam logic [3:0] S_MEM_WR  = 4'd7;
  localparam logic [3:0] S_WB_ALU  = 4'd8;
  localparam logic [3:0] S_WB_MEM  = 4'd9;
  localparam logic [3:0] S_EX_BR   = 4'd10;
  localparam logic [3:0] S_EX_J    = 4'd11;
  localparam logic [3:0] S_ILLEGAL = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0]    ALU_ADD = 3'b010;
  localparam logic [2:0]    ALU_SUB = 3'b110;
  localparam logic [TW-1:0] CNT_LIM = TW'(MEM_TIMEOUT);

  logic [3:0]    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          bus_err_q, bus_err_d;
  logic [2:0]    ex_aluc_q, ex_aluc_d;
  logic          ex_alusrc_q, ex_alusrc_d;
  logic          ex_rdst_q, ex_rdst_d;
  logic [2:0]    r_aluc;
  logic          r_ok;
  logic          taken;
  logic          wait_st;
  logic [3:0]    ret_st;

  // R-type funct to ALU operation
  always_comb begin
    r_aluc = ALU_ADD;
    r_ok   = 1'b1;
    case (funct)
      6'b100000: r_aluc = ALU_ADD;
      6'b100010: r_aluc = ALU_SUB;
      6'b100100: r_aluc = 3'b000;
      6'b100101: r_aluc = 3'b001;
      6'b101010: r_aluc = 3'b111;
      default:   r_ok   = 1'b0;
    endcase
  end

  assign taken   = (opcode == OP_BEQ) ? zero : !zero;
  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign ret_st  = run ? S_FETCH : S_IDLE;
  assign bus_err = bus_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    bus_err_d   = bus_err_q;
    ex_aluc_d   = ex_aluc_q;
    ex_alusrc_d = ex_alusrc_q;
    ex_rdst_d   = ex_rdst_q;
    ALUSrc      = 1'b0;
    RegDest     = 1'b0;
    aluc        = ALU_ADD;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'b00;
    illegal_op  = 1'b0;
    busy        = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: if (run && !bus_err_q) state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EX_R;
          OP_LW, OP_SW:  state_d = S_EX_ADDR;
          OP_BEQ, OP_BNE: state_d = S_EX_BR;
          OP_ADDI:       state_d = S_EX_ADDI;
          OP_J:          state_d = S_EX_J;
          default:       state_d = S_ILLEGAL;
        endcase
      end
      S_EX_R: begin
        aluc        = r_aluc;
        ex_aluc_d   = r_aluc;
        ex_alusrc_d = 1'b0;
        ex_rdst_d   = 1'b1;
        state_d     = r_ok ? S_WB_ALU : S_ILLEGAL;
      end
      S_EX_ADDI, S_EX_ADDR: begin
        ALUSrc      = 1'b1;
        ex_aluc_d   = ALU_ADD;
        ex_alusrc_d = 1'b1;
        ex_rdst_d   = 1'b0;
        if (state_q == S_EX_ADDI)  state_d = S_WB_ALU;
        else if (opcode == OP_LW)  state_d = S_MEM_RD;
        else                       state_d = S_MEM_WR;
      end
      // EX-phase ALU controls are held through write-back and memory phases
      S_WB_ALU: begin
        reg_write = 1'b1;
        aluc      = ex_aluc_q;
        ALUSrc    = ex_alusrc_q;
        RegDest   = ex_rdst_q;
        state_d   = ret_st;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        ALUSrc   = ex_alusrc_q;
        aluc     = ex_aluc_q;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        ALUSrc    = ex_alusrc_q;
        aluc      = ex_aluc_q;
        if (mem_ready) state_d = ret_st;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ret_st;
      end
      S_EX_BR: begin
        aluc    = ALU_SUB;
        pc_en   = taken;
        pc_src  = taken ? 2'b01 : 2'b00;
        state_d = ret_st;
      end
      S_EX_J: begin
        pc_en   = 1'b1;
        pc_src  = 2'b10;
        state_d = ret_st;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        state_d    = ret_st;
      end
      default: state_d = S_IDLE;
    endcase

    // Memory wait: ready in the cycle the count sits at the limit still succeeds
    if (wait_st && !mem_ready) begin
      if (cnt_q == CNT_LIM) begin
        state_d   = S_IDLE;
        bus_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
      ex_aluc_q   <= ALU_ADD;
      ex_alusrc_q <= 1'b0;
      ex_rdst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
      ex_aluc_q   <= ex_aluc_d;
      ex_alusrc_q <= ex_alusrc_d;
      ex_rdst_q   <= ex_rdst_d;
    end
  end

endmodule

// File: tb/tb_exe_seq_ctrl.sv
// Self-checking bench for exe_seq_ctrl: directed instruction table, reset and
// timeout sequences, and a randomized instruction stream against a cycle model.
module tb_exe_seq_ctrl;

  logic       clk, rst, run, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       ALUSrc, RegDest, iord, mem_read, mem_write, ir_write, reg_write;
  logic       mem_to_reg, pc_en, busy, illegal_op, bus_err;
  logic [2:0] aluc;
  logic [1:0] pc_src;

  exe_seq_ctrl #(.MEM_TIMEOUT(15), .TW(4)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .ALUSrc(ALUSrc), .RegDest(RegDest),
    .aluc(aluc), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_en(pc_en), .pc_src(pc_src), .busy(busy), .illegal_op(illegal_op),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       alusrc;
    logic       regdest;
    logic [2:0] aluc;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       busy;
    logic       illegal_op;
    logic       bus_err;
  } outs_t;

  typedef struct {
    logic       run;
    logic       mr;
    logic       z;
    logic [5:0] op;
    logic [5:0] fn;
    outs_t      exp;
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fs;
    int         ms;
    int         cyc;
    int         rw;
    int         pe;
    int         il;
  } vec_t;

  cyc_t q[$];
  vec_t tbl[19];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic outs_t sample();
    outs_t o;
    o.alusrc = ALUSrc;     o.regdest = RegDest;     o.aluc = aluc;
    o.iord = iord;         o.mem_read = mem_read;   o.mem_write = mem_write;
    o.ir_write = ir_write; o.reg_write = reg_write; o.mem_to_reg = mem_to_reg;
    o.pc_en = pc_en;       o.pc_src = pc_src;       o.busy = busy;
    o.illegal_op = illegal_op; o.bus_err = bus_err;
    return o;
  endfunction

  function automatic outs_t idle_o();
    outs_t o = '0;
    o.aluc = 3'b010;
    return o;
  endfunction

  function automatic outs_t busy_o();
    outs_t o = idle_o();
    o.busy = 1'b1;
    return o;
  endfunction

  // {valid, aluc} for an R-type funct
  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic mr, input logic z, input logic [5:0] op,
                      input logic [5:0] fn, input outs_t o);
    q.push_back('{1'b1, mr, z, op, fn, o});
  endtask

  // Reference: expected per-cycle outputs of one instruction, run held high
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fs, input int ms);
    outs_t o, m;
    logic [3:0] ra;
    logic tk;
    for (int i = 0; i < fs; i++) begin
      o = busy_o(); o.mem_read = 1'b1; push(1'b0, z, op, fn, o);
    end
    o = busy_o(); o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_en = 1'b1;
    push(1'b1, z, op, fn, o);
    push(1'($urandom), z, op, fn, busy_o());
    case (op)
      6'b000000: begin
        ra = r_alu(fn);
        o = busy_o(); o.aluc = ra[2:0]; push(1'($urandom), z, op, fn, o);
        if (ra[3]) begin
          o.reg_write = 1'b1; o.regdest = 1'b1; push(1'($urandom), z, op, fn, o);
        end else begin
          o = busy_o(); o.illegal_op = 1'b1; push(1'($urandom), z, op, fn, o);
        end
      end
      6'b001000: begin
        o = busy_o(); o.alusrc = 1'b1; push(1'($urandom), z, op, fn, o);
        o.reg_write = 1'b1; push(1'($urandom), z, op, fn, o);
      end
      6'b100011, 6'b101011: begin
        o = busy_o(); o.alusrc = 1'b1; push(1'($urandom), z, op, fn, o);
        m = o; m.iord = 1'b1;
        if (op == 6'b100011) m.mem_read = 1'b1; else m.mem_write = 1'b1;
        for (int i = 0; i < ms; i++) push(1'b0, z, op, fn, m);
        push(1'b1, z, op, fn, m);
        if (op == 6'b100011) begin
          o = busy_o(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
          push(1'($urandom), z, op, fn, o);
        end
      end
      6'b000100, 6'b000101: begin
        tk = (op == 6'b000100) ? z : !z;
        o = busy_o(); o.aluc = 3'b110; o.pc_en = tk; o.pc_src = tk ? 2'b01 : 2'b00;
        push(1'($urandom), z, op, fn, o);
      end
      6'b000010: begin
        o = busy_o(); o.pc_en = 1'b1; o.pc_src = 2'b10; push(1'($urandom), z, op, fn, o);
      end
      default: begin
        o = busy_o(); o.illegal_op = 1'b1; push(1'($urandom), z, op, fn, o);
      end
    endcase
  endtask

  // One instruction from IDLE with run pulsed once; memory stalls driven reactively
  task automatic run_one(input vec_t v, output int cyc, output int rw, output int pe,
                         output int il, output logic to);
    int fs_left, ms_left;
    fs_left = v.fs; ms_left = v.ms;
    cyc = 0; rw = 0; pe = 0; il = 0; to = 1'b1;
    opcode = v.op; funct = v.fn; zero = v.z; run = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (mem_read || mem_write) begin
        if (!iord && fs_left > 0) begin mem_ready = 1'b0; fs_left--; end
        else if (iord && ms_left > 0) begin mem_ready = 1'b0; ms_left--; end
        else mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom);
      end
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
      cyc++; rw += int'(reg_write); pe += int'(pc_en); il += int'(illegal_op);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rw, pe, il, sel;
    logic to, stuck;
    logic [5:0] op, fn;
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    outs_t o;

    //              op         funct      z   fs  ms  cyc rw pe il
    tbl[0]  = '{6'b000000, 6'b100000, 1'b0, 0,  0,  4, 1, 1, 0};
    tbl[1]  = '{6'b000000, 6'b100010, 1'b1, 2,  0,  6, 1, 1, 0};
    tbl[2]  = '{6'b000000, 6'b100100, 1'b0, 0,  0,  4, 1, 1, 0};
    tbl[3]  = '{6'b000000, 6'b100101, 1'b0, 0,  0,  4, 1, 1, 0};
    tbl[4]  = '{6'b000000, 6'b101010, 1'b0, 1,  0,  5, 1, 1, 0};
    tbl[5]  = '{6'b000000, 6'b000001, 1'b0, 0,  0,  4, 0, 1, 1};
    tbl[6]  = '{6'b001000, 6'b000000, 1'b0, 0,  0,  4, 1, 1, 0};
    tbl[7]  = '{6'b100011, 6'b000000, 1'b0, 0,  0,  5, 1, 1, 0};
    tbl[8]  = '{6'b100011, 6'b000000, 1'b0, 0,  3,  8, 1, 1, 0};
    tbl[9]  = '{6'b100011, 6'b000000, 1'b0, 0, 15, 20, 1, 1, 0};
    tbl[10] = '{6'b101011, 6'b000000, 1'b0, 0,  2,  6, 0, 1, 0};
    tbl[11] = '{6'b000100, 6'b000000, 1'b1, 0,  0,  3, 0, 2, 0};
    tbl[12] = '{6'b000100, 6'b000000, 1'b0, 0,  0,  3, 0, 1, 0};
    tbl[13] = '{6'b000101, 6'b000000, 1'b0, 0,  0,  3, 0, 2, 0};
    tbl[14] = '{6'b000101, 6'b000000, 1'b1, 0,  0,  3, 0, 1, 0};
    tbl[15] = '{6'b000010, 6'b000000, 1'b0, 0,  0,  3, 0, 2, 0};
    tbl[16] = '{6'b111111, 6'b000000, 1'b0, 0,  0,  3, 0, 1, 1};
    tbl[17] = '{6'b000000, 6'b100000, 1'b0, 15, 0, 19, 1, 1, 0};
    tbl[18] = '{6'b101011, 6'b000000, 1'b1, 3,  1,  8, 0, 1, 0};

    ops[0] = 6'b000000; ops[1] = 6'b001000; ops[2] = 6'b100011; ops[3] = 6'b101011;
    ops[4] = 6'b000100; ops[5] = 6'b000101; ops[6] = 6'b000010; ops[7] = 6'b110011;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010; fns[5] = 6'b000111;

    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    #12;
    check("reset_outputs", 32'(sample()), 32'(idle_o()));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle_without_run", 32'(sample()), 32'(idle_o()));

    foreach (tbl[i]) begin
      run_one(tbl[i], cyc, rw, pe, il, to);
      check($sformatf("vec%0d_done", i), 32'(to), 32'(0));
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
      check($sformatf("vec%0d_reg_write", i), 32'(rw), 32'(tbl[i].rw));
      check($sformatf("vec%0d_pc_en", i), 32'(pe), 32'(tbl[i].pe));
      check($sformatf("vec%0d_illegal", i), 32'(il), 32'(tbl[i].il));
      check($sformatf("vec%0d_bus_err", i), 32'(bus_err), 32'(0));
      @(posedge clk); #1;
    end

    // Asynchronous reset while a store waits in MEM_WR
    opcode = 6'b101011; funct = '0; run = 1'b1; mem_ready = 1'b1; to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      run = 1'b0;
      if (mem_write) begin mem_ready = 1'b0; to = 1'b0; break; end
    end
    check("reach_mem_wr", 32'(to), 32'(0));
    #2 rst = 1'b1;
    #1 check("rst_mid_mem_wr", 32'(sample()), 32'(idle_o()));
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", 32'(sample()), 32'(idle_o()));

    // Randomized back-to-back stream against the cycle model
    q.delete();
    q.push_back('{1'b1, 1'($urandom), 1'b0, 6'b0, 6'b0, idle_o()});
    add_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
    add_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
    add_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    add_instr(6'b000101, 6'b000000, 1'b1, 1, 0);
    add_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 7));
      op = ops[sel];
      if (sel == 7) op = 6'($urandom);
      fn = fns[$urandom_range(0, 5)];
      add_instr(op, fn, 1'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
    end
    foreach (q[i]) begin
      run = q[i].run; mem_ready = q[i].mr; zero = q[i].z;
      opcode = q[i].op; funct = q[i].fn;
      @(negedge clk);
      check($sformatf("stream_cycle%0d", i), 32'(sample()), 32'(q[i].exp));
      @(posedge clk); #1;
    end
    rst = 1'b1; run = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Fetch never acknowledged: timeout, sticky error, run ignored
    run = 1'b1; mem_ready = 1'b0; opcode = '0; funct = 6'b100000;
    @(posedge clk); #1;
    cyc = 0; to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
      cyc++;
      @(posedge clk); #1;
    end
    check("timeout_done", 32'(to), 32'(0));
    check("timeout_fetch_cycles", 32'(cyc), 32'(16));
    o = idle_o(); o.bus_err = 1'b1;
    check("timeout_state", 32'(sample()), 32'(o));
    mem_ready = 1'b1; stuck = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (busy || mem_read) stuck = 1'b1;
    end
    check("bus_err_blocks_run", 32'(stuck), 32'(0));
    check("bus_err_sticky", 32'(bus_err), 32'(1));
    rst = 1'b1;
    #1 check("bus_err_cleared", 32'(bus_err), 32'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("restart_fetch", 32'(busy && mem_read), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
